// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair: segment
// constants (active-high gfedcba), decode result structs and helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } hex_dec_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } an_dec_t;

  // Active-high segment pattern to hex value; hit=0 for non-hex patterns.
  function automatic hex_dec_t seg_to_hex(input logic [6:0] seg_hi);
    hex_dec_t r;
    r.hit    = 1'b1;
    r.nibble = 4'h0;
    case (seg_hi)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.hit    = 1'b0;
    endcase
    return r;
  endfunction

  // True when exactly one active-low anode strobe is asserted.
  function automatic logic an_is_onehot(input logic [3:0] an_n);
    logic [3:0] sel;
    sel = ~an_n;
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  // Active-low one-hot anode strobes to digit index.
  function automatic an_dec_t an_to_index(input logic [3:0] an_n);
    an_dec_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (an_n)
      4'b1110: r.idx   = 2'd0;
      4'b1101: r.idx   = 2'd1;
      4'b1011: r.idx   = 2'd2;
      4'b0111: r.idx   = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment bus into {hit, nibble}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  hex_dec_t dec;

  assign dec    = seg_to_hex(~seg);
  assign hit    = dec.hit;
  assign nibble = dec.nibble;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 4-digit seven-segment bus, recovers the displayed
// hex digits, reports completed refresh frames and flags a stalled display.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_pulse,
  output logic        frame_valid,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [SW-1:0] settle_cnt;   // edges the current registered value has held
  logic          captured;     // this dwell has already been captured
  logic [3:0]    seen;
  logic [TW-1:0] idle_cnt;

  an_dec_t    cur_an;
  logic       in_valid;
  logic       changed;
  logic       capture;
  logic       hit;
  logic [3:0] nibble;
  logic [3:0] cur_onehot;
  logic [3:0] seen_next;
  logic       frame_done;

  seg7_pattern_decode u_decode (
    .seg    (seg_q),
    .hit    (hit),
    .nibble (nibble)
  );

  // Settle counting compares the incoming value against the registered one,
  // so the count equals the number of edges the registered value has held.
  assign cur_an     = an_to_index(an_q);
  assign in_valid   = an_is_onehot(an);
  assign changed    = ({an, seg} != {an_q, seg_q});
  assign capture    = cur_an.valid && (settle_cnt == SETTLE_MAX) && !captured;
  assign cur_onehot = 4'b0001 << cur_an.idx;
  assign seen_next  = seen | cur_onehot;
  assign frame_done = capture && (seen_next == 4'hF);

  // Input register, settle counter and one-capture-per-dwell flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q       <= 4'd0;
      seg_q      <= 7'd0;
      settle_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      if (!in_valid)
        settle_cnt <= '0;
      else if (changed)
        settle_cnt <= SW'(1);
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + SW'(1);
      if (changed)
        captured <= 1'b0;
      else if (capture)
        captured <= 1'b1;
    end
  end

  // Per-digit value and error registers, written on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits    <= 16'd0;
      digit_err <= 4'd0;
    end else if (capture) begin
      if (hit) begin
        digits[{cur_an.idx, 2'b00} +: 4] <= nibble;
        digit_err[cur_an.idx]            <= 1'b0;
      end else begin
        digit_err[cur_an.idx]            <= 1'b1;
      end
    end
  end

  // Frame tracker and no-capture timeout; a capture always beats the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen        <= 4'd0;
      idle_cnt    <= '0;
      frame_pulse <= 1'b0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      if (capture) begin
        idle_cnt <= '0;
        if (frame_done) begin
          frame_pulse <= 1'b1;
          frame_valid <= 1'b1;
          stale       <= 1'b0;
          seen        <= 4'd0;
        end else begin
          seen <= seen_next;
        end
      end else if (idle_cnt != TIMEOUT_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
        if (idle_cnt == TIMEOUT_LAST) begin
          stale       <= 1'b1;
          frame_valid <= 1'b0;
          seen        <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random scanning,
// every cycle compared against a behavioural model of the display rules.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int T = 1024;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_pulse;
  logic        frame_valid;
  logic        stale;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_pulse (frame_pulse),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  // ---------------- reference model ----------------
  // Active-high gfedcba patterns for hex 0..F.
  logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int model_hex(logic [6:0] pat_hi);
    for (int i = 0; i < 16; i++)
      if (hex_seg[i] == pat_hi) return i;
    return -1;
  endfunction

  function automatic int digit_of(logic [3:0] a);
    int n;
    int idx;
    n = 0;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin
        n++;
        idx = i;
      end
    return (n == 1) ? idx : -1;
  endfunction

  logic [10:0] m_prev;     // value held in the input register
  int          m_run;      // consecutive edges that value has been registered
  bit          m_done;     // dwell already captured
  logic [15:0] m_digits;
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  bit          m_pulse, m_valid, m_stale;
  int          m_idle;
  int          m_idx, m_h;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = '0; m_run = 0; m_done = 0;
      m_digits = '0; m_err = '0; m_seen = '0;
      m_pulse = 0; m_valid = 0; m_stale = 0; m_idle = 0;
    end else begin
      m_pulse = 0;
      m_idx = digit_of(m_prev[10:7]);
      if (m_idx >= 0 && m_run >= S && !m_done) begin
        m_done = 1;
        m_h = model_hex(~m_prev[6:0]);
        if (m_h >= 0) begin
          m_digits[m_idx*4 +: 4] = m_h[3:0];
          m_err[m_idx] = 1'b0;
        end else begin
          m_err[m_idx] = 1'b1;
        end
        m_seen[m_idx] = 1'b1;
        m_idle = 0;
        if (m_seen == 4'hF) begin
          m_pulse = 1; m_valid = 1; m_stale = 0; m_seen = '0;
        end
      end else if (m_idle < T) begin
        m_idle++;
        if (m_idle == T) begin
          m_stale = 1; m_valid = 0; m_seen = '0;
        end
      end
      if ({an, seg} == m_prev) m_run++;
      else begin
        m_prev = {an, seg};
        m_run  = 1;
        m_done = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit pulse_stale, pulse_valid;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, digits, digit_err, frame_pulse, frame_valid, stale};
  endfunction

  task automatic cycle_check();
    exp_q.push_back({9'd0, m_digits, m_err, m_pulse, m_valid, m_stale});
    check("outs", outs(), exp_q.pop_front());
    if (frame_pulse) begin
      pulse_cnt++;
      pulse_stale = stale;
      pulse_valid = frame_valid;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_check();
      an  = a;
      seg = s;
    end
  endtask

  task automatic show(input int idx, input int val, input int n);
    drive(~(4'b0001 << idx), ~hex_seg[val], n);
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3);
    show(0, v0, 16);
    show(1, v1, 16);
    show(2, v2, 16);
    show(3, v3, 16);
    drive(4'hF, 7'h7F, 4);
  endtask

  // ---------------- stimulus ----------------
  int p;
  int k, d;

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    drive(4'hF, 7'h7F, 3);
    @(negedge clk);
    cycle_check();
    check("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;

    // Basic capture
    scan(1, 2, 3, 4);
    check("basic_digits", {16'd0, digits}, 32'h4321);
    check("basic_err", {28'd0, digit_err}, 32'd0);
    check("basic_valid", {31'd0, frame_valid}, 32'd1);
    check("basic_pulses", pulse_cnt, 1);

    // Glitch shorter than the settle window on digit 0
    p = pulse_cnt;
    drive(4'b1110, 7'h40, S - 1);
    drive(4'hF, 7'h7F, 4);
    check("glitch_digits", {16'd0, digits}, 32'h4321);
    show(1, 2, 16); show(2, 3, 16); show(3, 4, 16);
    drive(4'hF, 7'h7F, 4);
    check("glitch_no_frame", pulse_cnt, p);
    show(0, 1, 16);
    drive(4'hF, 7'h7F, 4);
    check("glitch_frame_done", pulse_cnt, p + 1);

    // Non-hex pattern on digit 2, then a valid 0
    drive(4'b1011, 7'h7F, 16);
    drive(4'hF, 7'h7F, 4);
    check("nonhex_err", {28'd0, digit_err}, 32'h4);
    check("nonhex_nibble", {28'd0, digits[11:8]}, 32'h3);
    show(0, 1, 16); show(1, 2, 16);
    drive(4'b1011, 7'h40, 16);
    show(3, 4, 16);
    drive(4'hF, 7'h7F, 4);
    check("nonhex_clear_err", {28'd0, digit_err}, 32'd0);
    check("nonhex_digits", {16'd0, digits}, 32'h4021);

    // Invalid anodes, then stop scanning until stale
    p = pulse_cnt;
    drive(4'b1100, 7'h40, 50);
    check("invalid_digits", {16'd0, digits}, 32'h4021);
    check("invalid_no_pulse", pulse_cnt, p);
    for (int i = 0; i < 2 * T && !stale; i++) drive(4'hF, 7'h7F, 1);
    check("stale_rise", {31'd0, stale}, 32'd1);
    check("stale_valid_low", {31'd0, frame_valid}, 32'd0);
    check("stale_digits_held", {16'd0, digits}, 32'h4021);

    // Recovery
    p = pulse_cnt;
    scan(5, 6, 7, 8);
    check("recover_pulse", pulse_cnt, p + 1);
    check("recover_stale_at_pulse", {31'd0, pulse_stale}, 32'd0);
    check("recover_valid_at_pulse", {31'd0, pulse_valid}, 32'd1);
    check("recover_digits", {16'd0, digits}, 32'h8765);

    // Reset mid-frame for exactly one edge
    show(0, 9, 16);
    show(1, 10, 16);
    rst_n = 1'b0;
    drive(4'hF, 7'h7F, 1);
    @(negedge clk);
    cycle_check();
    check("midreset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    p = pulse_cnt;
    show(2, 11, 16); show(3, 12, 16);
    drive(4'hF, 7'h7F, 4);
    check("midreset_no_frame", pulse_cnt, p);
    check("midreset_digits", {16'd0, digits}, 32'hCB00);
    scan(13, 14, 15, 0);
    check("midreset_frame", pulse_cnt, p + 1);
    check("midreset_full_digits", {16'd0, digits}, 32'h0FED);

    // Random scanning, dwell lengths around the settle window
    for (int r = 0; r < 300; r++) begin
      k = $urandom_range(0, 9);
      d = $urandom_range(1, 8);
      if (k < 7)
        show($urandom_range(0, 3), $urandom_range(0, 15), d);
      else if (k == 7)
        drive(~(4'b0001 << $urandom_range(0, 3)), 7'($urandom), d);
      else if (k == 8)
        drive(4'hF, 7'h7F, d);
      else
        drive(4'($urandom), 7'($urandom), d);
    end
    drive(4'hF, 7'h7F, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver: watches the active-low segment bus and active-low anode strobes that `top` drives on the board.
- Recovers the four displayed hex digits and flags patterns that are not hex.
- Reports complete refresh frames and detects a display that has stopped scanning.
- Sits in loopback/self-check builds and benches, wired directly to `top`'s `bcd`/`an` outputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: consecutive cycles a segment/anode value must hold before capture; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1024: cycles without any capture before the display is declared stale; must be > `SETTLE_CYCLES`.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `seg`, input, 7: segment bus, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`, input, 4: anode strobes, active-low; `an[i]` low selects digit i.
- `digits`, output, 16: `digits[4i+3:4i]` is the last captured value of digit i.
- `digit_err`, output, 4: bit i is set when digit i's last capture was a non-hex pattern.
- `frame_pulse`, output, 1: one-cycle pulse when all four digits have been captured since the last pulse.
- `frame_valid`, output, 1: high from the first `frame_pulse` until stale or reset.
- `stale`, output, 1: no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- **Input register.** `seg`/`an` are registered once. There is no synchroniser: the source is in the same clock domain.
- **Anode decode.**
  - Exactly one `an` bit low gives the digit index.
  - All bits high (blanking) or more than one bit low is invalid: no capture, and the settle count clears.
- **Settle.**
  - The counter increments each cycle the registered `{an,seg}` equals the previous cycle's value.
  - The counter clears on any change and saturates.
  - One capture per dwell: after capturing, a `captured` flag blocks re-capture until `{an,seg}` changes.
- **Segment decode** (on the inverted, active-high `gfedcba` value):
  - Hex table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Match: nibble i is written and `digit_err[i]` clears.
  - No match: nibble i is kept and `digit_err[i]` is set.
- **Frame tracking.**
  - `seen[3:0]` sets bit i on every capture of digit i, valid or error.
  - When a capture makes `seen`=F, in that same cycle: `frame_pulse`=1, `frame_valid`=1, `stale` clears, and `seen` clears to 0.
  - Repeated captures of the same digit do not advance the frame.
- **Timeout.**
  - The counter clears on every capture and saturates at `TIMEOUT_CYCLES`.
  - On reaching it: `stale`=1, `frame_valid`=0, `seen` clears.
  - `digits` and `digit_err` hold their values while stale.

## Timing
- **Reset values.** While `rst_n`=0 at an edge: `digits`=0, `digit_err`=0, `frame_pulse`=0, `frame_valid`=0, `stale`=0. Input register, counters, `seen` and `captured` all clear.
- **Reset mid-operation.** Behaviour resumes as from power-up. The first capture needs a full settle measured from the first edge after reset release.
- **Capture latency.** Let edge k be the first edge that registers a new valid `{an,seg}` value held constant. Then `digits`/`digit_err` update at edge k+`SETTLE_CYCLES`.
- **Frame pulse.** `frame_pulse` is asserted in the same cycle the completing digit updates.
- **Glitch rejection.** A value held fewer than `SETTLE_CYCLES` cycles is never captured.
- **Simultaneous capture and timeout.** The capture wins: the timeout counter clears and `stale` is not set.
- **Stale timing.** `stale` rises at the edge where the no-capture count reaches `TIMEOUT_CYCLES`.
- **Outputs.** All outputs are registered; no combinational input-to-output path.

## Structure
- **Package `seg7_pkg`:**
  - The 16 active-high segment constants.
  - A `seg_to_hex` function returning `{hit, nibble}`.
  - The anode one-hot-to-index function.
  - The encoder side uses the same package.
- **Sub-module `seg7_pattern_decode`:** combinational `seg` → `{hit, nibble}`, instantiated once after the input register.
- **Remainder of the block:** settle counter, `captured` flag, per-digit registers, frame tracker and timeout counter.

## Test plan
1. **Basic capture.** Reset, then scan digits 0..3 showing 1, 2, 3, 4 (`seg` = 79, 24, 30, 19 active-low), 16 cycles per digit.
   - `digits`=4321, one `frame_pulse`, `frame_valid`=1, `digit_err`=0.
   - Each digit updates exactly `SETTLE_CYCLES` edges after its anode first registers.
2. **Glitch.** Present `an`=1110, `seg`=40 for `SETTLE_CYCLES`-1 cycles, then `an`=1111.
   - `digits` unchanged; `seen` not advanced.
3. **Non-hex pattern.** Digit 2 shows `seg`=7F (active-low blank), then a later frame shows 0 (`seg`=40).
   - `digit_err`=4 and nibble 2 unchanged after the first.
   - `digit_err`=0 and nibble 2 = 0 after the second.
4. **Invalid anodes.** Drive `an`=1100 for 50 cycles.
   - No capture; the timeout counter keeps running.
5. **Stale and recovery.** Stop scanning for `TIMEOUT_CYCLES` cycles.
   - `stale`=1 and `frame_valid`=0 at the exact edge; `digits` held.
   - Resume a full scan: `stale`=0 and `frame_valid`=1 on the `frame_pulse`.
6. **Reset mid-frame.** Assert `rst_n`=0 for one edge after digits 0–1 are captured.
   - All outputs return to reset values.
   - The next frame needs all four digits again.
